data_mem_responder: RTL and testbench

- Data-memory responder for the 32-bit RISC-V pipeline's MEM stage. It is the target side of the load/store request interface that the pipeline drives.
- Accepts one load or store request at a time over a valid/ready handshake. The request carries address, write data, write enable and funct3.
- Performs the access on an internal word-organised array after a configurable latency. Returns a one-cycle response with the sign- or zero-extended load data or an error flag.
- Exposes busy so the hazard logic can stall the pipeline while an access is in flight.

---
 rtl/data_mem_responder.sv | 166 ++++++++++++++++
 tb/tb_data_mem_responder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Data-memory responder for the MEM stage: accepts one load/store at a time,
// performs it on a word array after LATENCY edges and returns a one-cycle response.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int IDX_W  = $clog2(DEPTH_WORDS);
    localparam int CNT_W  = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
    localparam int LAT_M2 = (LATENCY >= 2) ? LATENCY - 2 : 0;
    localparam logic [33:0] ADDR_LIMIT = 34'(DEPTH_WORDS) << 2;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state, state_next;
    logic [CNT_W-1:0]  counter;
    logic              we_q;
    logic [31:0]       addr_q;
    logic [31:0]       wdata_q;
    logic [2:0]        funct3_q;
    logic [31:0]       mem [DEPTH_WORDS];

    logic              accept;
    logic              enter_resp;
    logic              acc_we;
    logic [31:0]       acc_addr;
    logic [31:0]       acc_wdata;
    logic [2:0]        acc_funct3;
    logic [IDX_W-1:0]  acc_idx;
    logic [1:0]        lane;
    logic [31:0]       rd_word;
    logic              acc_err;
    logic [31:0]       load_data;
    logic [3:0]        wr_mask;
    logic [31:0]       wr_data;
    logic              do_write;
    logic [7:0]        sel_byte;
    logic [15:0]       sel_half;

    assign req_ready = (state == IDLE) && !rst;
    assign busy      = (state != IDLE);
    assign rsp_valid = (state == RESP);

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept     = 1'b1;
                    state_next = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (counter == '0) begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        enter_resp = !rst && (state != RESP) && (state_next == RESP);
    end

    // With LATENCY = 1 the access happens on the accepting edge, so use live inputs.
    assign acc_we     = (state == IDLE) ? req_we     : we_q;
    assign acc_addr   = (state == IDLE) ? req_addr   : addr_q;
    assign acc_wdata  = (state == IDLE) ? req_wdata  : wdata_q;
    assign acc_funct3 = (state == IDLE) ? req_funct3 : funct3_q;
    assign acc_idx    = acc_addr[IDX_W+1:2];
    assign lane       = acc_addr[1:0];
    assign rd_word    = mem[acc_idx];
    assign sel_byte   = rd_word[{lane, 3'b000} +: 8];
    assign sel_half   = lane[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        acc_err   = 1'b0;
        load_data = '0;
        wr_mask   = '0;
        wr_data   = '0;
        case (acc_funct3[1:0])
            2'b00: begin
                load_data = acc_funct3[2] ? {24'b0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
                wr_mask   = 4'b0001 << lane;
                wr_data   = {4{acc_wdata[7:0]}};
            end
            2'b01: begin
                if (lane[0]) begin
                    acc_err = 1'b1;
                end
                load_data = acc_funct3[2] ? {16'b0, sel_half} : {{16{sel_half[15]}}, sel_half};
                wr_mask   = lane[1] ? 4'b1100 : 4'b0011;
                wr_data   = {2{acc_wdata[15:0]}};
            end
            2'b10: begin
                if (lane != 2'b00 || acc_funct3[2]) begin
                    acc_err = 1'b1;
                end
                load_data = rd_word;
                wr_mask   = 4'b1111;
                wr_data   = acc_wdata;
            end
            default: acc_err = 1'b1;
        endcase
        if (acc_we && acc_funct3[2]) begin
            acc_err = 1'b1;
        end
        if ({2'b00, acc_addr} >= ADDR_LIMIT) begin
            acc_err = 1'b1;
        end
        do_write = enter_resp && acc_we && !acc_err;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            counter   <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            funct3_q  <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                we_q     <= req_we;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                funct3_q <= req_funct3;
                counter  <= CNT_W'(LAT_M2);
            end else if (state == WAIT && counter != '0) begin
                counter <= counter - CNT_W'(1);
            end
            if (enter_resp) begin
                rsp_rdata <= (acc_we || acc_err) ? 32'h0 : load_data;
                rsp_err   <= acc_err;
            end
        end
    end

    // Array has no reset; byte enables keep untouched lanes intact on SB/SH.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_mask[b]) begin
                    mem[acc_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: LATENCY=2/1024 words and LATENCY=1/16 words.
module tb_data_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid, req_ready, req_we, rsp_valid, rsp_err, busy;
    logic [31:0] req_addr, req_wdata, rsp_rdata;
    logic [2:0]  req_funct3;
    logic        req_valid_l1, req_ready_l1, req_we_l1, rsp_valid_l1, rsp_err_l1, busy_l1;
    logic [31:0] req_addr_l1, req_wdata_l1, rsp_rdata_l1;
    logic [2:0]  req_funct3_l1;

    data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_funct3(req_funct3), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy)
    );

    data_mem_responder #(.DEPTH_WORDS(16), .LATENCY(1)) dut_l1 (
        .clk(clk), .rst(rst), .req_valid(req_valid_l1), .req_ready(req_ready_l1),
        .req_we(req_we_l1), .req_addr(req_addr_l1), .req_wdata(req_wdata_l1),
        .req_funct3(req_funct3_l1), .rsp_valid(rsp_valid_l1), .rsp_rdata(rsp_rdata_l1),
        .rsp_err(rsp_err_l1), .busy(busy_l1)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc_cyc;
    } exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    exp_t sb0[$];
    exp_t sb1[$];
    vec_t v1[7];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic reportTimeout(input string name);
        tests++;
        fails++;
        $display("[TB] FAIL %s: timed out waiting for req_ready", name);
    endtask

    // Scoreboard monitors: response for LATENCY=2 appears one edge after the accept edge
    always @(negedge clk) begin
        if (rsp_valid) begin
            if (sb0.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL unexpected_rsp: got rsp_valid=1 expected none at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = sb0.pop_front();
                checkOutput("rsp_rdata", rsp_rdata, e.rdata);
                checkOutput("rsp_err", 32'(rsp_err), 32'(e.err));
                checkOutput("rsp_cycle", cyc, e.acc_cyc + 1);
            end
        end
    end

    always @(negedge clk) begin
        if (rsp_valid_l1) begin
            if (sb1.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL unexpected_rsp_l1: got rsp_valid=1 expected none at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = sb1.pop_front();
                checkOutput("rsp_rdata_l1", rsp_rdata_l1, e.rdata);
                checkOutput("rsp_err_l1", 32'(rsp_err_l1), 32'(e.err));
                checkOutput("rsp_cycle_l1", cyc, e.acc_cyc);
            end
        end
    end

    task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [2:0] f3, input logic [31:0] exp_rdata,
                                 input logic exp_err, input bit expect_rsp);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            reportTimeout("apply_ready");
            return;
        end
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_wdata  = wdata;
        req_funct3 = f3;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (expect_rsp) sb0.push_back('{exp_rdata, exp_err, cyc});
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int i, last, guard;
        v1[0] = '{1'b1, 32'h04, 32'h01020304, 3'b010, 32'h0,        1'b0};
        v1[1] = '{1'b0, 32'h04, 32'h0,        3'b010, 32'h01020304, 1'b0};
        v1[2] = '{1'b0, 32'h05, 32'h0,        3'b100, 32'h00000003, 1'b0};
        v1[3] = '{1'b0, 32'h06, 32'h0,        3'b001, 32'h00000102, 1'b0};
        v1[4] = '{1'b1, 32'h44, 32'hFFFFFFFF, 3'b010, 32'h0,        1'b1};
        v1[5] = '{1'b0, 32'h04, 32'h0,        3'b010, 32'h01020304, 1'b0};
        v1[6] = '{1'b0, 32'h07, 32'h0,        3'b000, 32'h00000001, 1'b0};

        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_funct3 = '0;
        req_valid_l1 = 1'b0; req_we_l1 = 1'b0; req_addr_l1 = '0; req_wdata_l1 = '0; req_funct3_l1 = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_ready", 32'(req_ready), 32'h0);
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        checkOutput("reset_rdata", rsp_rdata, 32'h0);
        checkOutput("reset_err", 32'(rsp_err), 32'h0);
        checkOutput("reset_busy", 32'(busy), 32'h0);
        checkOutput("reset_ready_l1", 32'(req_ready_l1), 32'h0);

        // Request held valid across reset is taken on the first edge after release
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'hDEADBEEF; req_funct3 = 3'b010;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_reset", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        sb0.push_back('{32'h0, 1'b0, cyc});
        @(negedge clk);
        checkOutput("wait_ready", 32'(req_ready), 32'h0);
        checkOutput("wait_busy", 32'(busy), 32'h1);
        checkOutput("wait_rsp_valid", 32'(rsp_valid), 32'h0);
        @(negedge clk);
        checkOutput("resp_ready", 32'(req_ready), 32'h0);
        checkOutput("resp_rsp_valid", 32'(rsp_valid), 32'h1);
        @(negedge clk);
        checkOutput("idle_ready", 32'(req_ready), 32'h1);
        checkOutput("idle_rsp_valid", 32'(rsp_valid), 32'h0);

        applyStimulus(1'b0, 32'h10, 32'h0,        3'b010, 32'hDEADBEEF, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h13, 32'h00000080, 3'b000, 32'h0,        1'b0, 1'b1);
        applyStimulus(1'b0, 32'h10, 32'h0,        3'b010, 32'h80ADBEEF, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'h13, 32'h0,        3'b000, 32'hFFFFFF80, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'h13, 32'h0,        3'b100, 32'h00000080, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'h12, 32'h0,        3'b001, 32'hFFFF80AD, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'h10, 32'h0,        3'b101, 32'h0000BEEF, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'h11, 32'h0,        3'b001, 32'h0,        1'b1, 1'b1);
        applyStimulus(1'b1, 32'h12, 32'h12345678, 3'b010, 32'h0,        1'b1, 1'b1);
        applyStimulus(1'b0, 32'h10, 32'h0,        3'b011, 32'h0,        1'b1, 1'b1);
        applyStimulus(1'b0, 32'h10, 32'h0,        3'b010, 32'h80ADBEEF, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h00, 32'hCAFEF00D, 3'b010, 32'h0,        1'b0, 1'b1);
        applyStimulus(1'b1, 32'h1000, 32'h12345678, 3'b010, 32'h0,      1'b1, 1'b1);
        applyStimulus(1'b0, 32'h00, 32'h0,        3'b010, 32'hCAFEF00D, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'h02, 32'hAAAA5555, 3'b001, 32'h0,        1'b0, 1'b1);
        applyStimulus(1'b0, 32'h00, 32'h0,        3'b010, 32'h5555F00D, 1'b0, 1'b1);
        applyStimulus(1'b1, 32'hFFC, 32'h0BADCAFE, 3'b010, 32'h0,       1'b0, 1'b1);
        applyStimulus(1'b0, 32'hFFC, 32'h0,       3'b010, 32'h0BADCAFE, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'h1003, 32'h0,      3'b000, 32'h0,        1'b1, 1'b1);
        applyStimulus(1'b1, 32'h20, 32'h11111111, 3'b010, 32'h0,        1'b0, 1'b1);

        // Store dropped by a reset pulse landing on its access edge
        applyStimulus(1'b1, 32'h20, 32'h22222222, 3'b010, 32'h0, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("ready_in_midreset", 32'(req_ready), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_midreset", 32'(req_ready), 32'h1);
        repeat (3) @(negedge clk);
        applyStimulus(1'b0, 32'h20, 32'h0, 3'b010, 32'h11111111, 1'b0, 1'b1);

        // LATENCY=1 instance with req_valid held high back to back
        i = 0; last = -1; guard = 0;
        while (i < 7 && guard < 100) begin
            @(negedge clk);
            guard++;
            checkOutput("busy_vs_ready_l1", 32'(busy_l1), 32'(!req_ready_l1));
            if (req_ready_l1) begin
                req_valid_l1  = 1'b1;
                req_we_l1     = v1[i].we;
                req_addr_l1   = v1[i].addr;
                req_wdata_l1  = v1[i].wdata;
                req_funct3_l1 = v1[i].f3;
                @(posedge clk);
                #1;
                sb1.push_back('{v1[i].rdata, v1[i].err, cyc});
                if (last >= 0) checkOutput("accept_gap_l1", cyc - last, 32'd2);
                last = cyc;
                i++;
            end
        end
        req_valid_l1 = 1'b0;
        if (i < 7) reportTimeout("l1_stream");

        repeat (6) @(negedge clk);
        checkOutput("sb0_drained", sb0.size(), 32'd0);
        checkOutput("sb1_drained", sb1.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
